// File: rtl/monitor_pkg.sv
// Shared definitions for the monitor FIFO read-out path: reader FSM states,
// FIFO slave register offsets and record counter width.
package monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        OUT
    } mon_state_e;

    localparam int unsigned MON_ADR_OFFSET  = 0;
    localparam int unsigned MON_DAT_OFFSET  = 1;
    localparam int unsigned REC_COUNT_WIDTH = 16;

endpackage

// File: rtl/monitor_fifo_reader.sv
// Avalon-MM master that pops (address, data) records from the monitor FIFO
// and presents them on a valid/ready stream, masking the FIFO's stale empty.
module monitor_fifo_reader
    import monitor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       fifo_empty,
    output logic [ADDRESS_WIDTH-1:0]   avm_address,
    output logic                       avm_read,
    input  logic [DATA_WIDTH-1:0]      avm_readdata,
    input  logic                       avm_waitrequest,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [ADDRESS_WIDTH-1:0]   rec_addr,
    output logic [DATA_WIDTH-1:0]      rec_data,
    output logic [REC_COUNT_WIDTH-1:0] rec_count,
    output logic                       busy
);

    localparam logic [ADDRESS_WIDTH-1:0] ADR_OFS     = ADDRESS_WIDTH'(MON_ADR_OFFSET);
    localparam logic [ADDRESS_WIDTH-1:0] DAT_OFS     = ADDRESS_WIDTH'(MON_DAT_OFFSET);
    localparam logic [2:0]               SETTLE_LOAD = 3'(SETTLE_CYCLES);

    mon_state_e                 state_q, state_d;
    logic [2:0]                 settle_q, settle_d;
    logic                       avm_read_q, avm_read_d;
    logic [ADDRESS_WIDTH-1:0]   avm_address_q, avm_address_d;
    logic                       rec_valid_q, rec_valid_d;
    logic [ADDRESS_WIDTH-1:0]   rec_addr_q, rec_addr_d;
    logic [DATA_WIDTH-1:0]      rec_data_q, rec_data_d;
    logic [REC_COUNT_WIDTH-1:0] rec_count_q, rec_count_d;
    logic                       busy_q, busy_d;
    logic                       accept;

    assign accept = avm_read_q && !avm_waitrequest;

    always_comb begin
        state_d     = state_q;
        settle_d    = (settle_q != '0) ? settle_q - 3'd1 : '0;
        rec_addr_d  = rec_addr_q;
        rec_data_d  = rec_data_q;
        rec_count_d = rec_count_q;

        unique case (state_q)
            IDLE: begin
                if (enable && !fifo_empty && settle_q == '0) begin
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (accept) begin
                    rec_addr_d = avm_readdata[ADDRESS_WIDTH-1:0];
                    state_d    = RD_DATA;
                end
            end
            RD_DATA: begin
                // The pop makes fifo_empty stale; the settle counter blocks relaunch until it is trusted.
                if (accept) begin
                    rec_data_d  = avm_readdata;
                    rec_count_d = rec_count_q + 1'b1;
                    settle_d    = SETTLE_LOAD;
                    state_d     = flush ? IDLE : OUT;
                end
            end
            OUT: begin
                if (rec_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered.
        avm_read_d    = (state_d == RD_ADDR) || (state_d == RD_DATA);
        avm_address_d = (state_d == RD_DATA) ? DAT_OFS : ADR_OFS;
        rec_valid_d   = (state_d == OUT);
        busy_d        = (state_d != IDLE) || (settle_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            settle_q      <= '0;
            avm_read_q    <= 1'b0;
            avm_address_q <= '0;
            rec_valid_q   <= 1'b0;
            rec_addr_q    <= '0;
            rec_data_q    <= '0;
            rec_count_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            rec_valid_q   <= rec_valid_d;
            rec_addr_q    <= rec_addr_d;
            rec_data_q    <= rec_data_d;
            rec_count_q   <= rec_count_d;
            busy_q        <= busy_d;
        end
    end

    assign avm_read    = avm_read_q;
    assign avm_address = avm_address_q;
    assign rec_valid   = rec_valid_q;
    assign rec_addr    = rec_addr_q;
    assign rec_data    = rec_data_q;
    assign rec_count   = rec_count_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_monitor_fifo_reader.sv
// Bench for monitor_fifo_reader: behavioural FIFO slave with lagging empty flag,
// record scoreboard checked whenever the reader presents a record.
module tb_monitor_fifo_reader;
    import monitor_pkg::*;

    localparam int unsigned DW        = 32;
    localparam int unsigned AW        = 10;
    localparam int unsigned S         = 2;
    localparam int unsigned EMPTY_LAG = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic [DW-1:0] avm_readdata = '0;
    logic          avm_waitrequest = 1'b1;
    logic          rec_valid;
    logic          rec_ready = 1'b0;
    logic [AW-1:0] rec_addr;
    logic [DW-1:0] rec_data;
    logic [15:0]   rec_count;
    logic          busy;

    always #5 clk = ~clk;

    monitor_fifo_reader #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .flush           (flush),
        .fifo_empty      (fifo_empty),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .rec_valid       (rec_valid),
        .rec_ready       (rec_ready),
        .rec_addr        (rec_addr),
        .rec_data        (rec_data),
        .rec_count       (rec_count),
        .busy            (busy)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } rec_t;

    rec_t                 fifo_q[$];
    rec_t                 exp_q[$];
    logic [15:0]          ref_count = '0;
    logic [EMPTY_LAG-1:0] empty_pipe = '1;
    bit                   stalled = 0;
    bit                   expect_data = 0;
    logic                 prev_read = 1'b0;
    logic                 prev_valid = 1'b0;
    int                   cyc = 0;
    int                   last_launch = -1000;
    int                   launch_cyc = 0;
    int                   accepts = 0;
    int                   handshakes = 0;
    int                   checks = 0;
    int                   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor first (sees pre-edge model state), then the FIFO slave drives the next cycle.
    always @(negedge clk) begin
        rec_t            h;
        logic [DW-1:0]   w;
        cyc++;

        check("rec_count", rec_count, ref_count);
        if (avm_read || rec_valid) check("busy_when_active", busy, 1'b1);
        if (rec_valid) begin
            check("sb_nonempty_on_valid", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                check("rec_addr", rec_addr, exp_q[0].a);
                check("rec_data", rec_data, exp_q[0].d);
                if (rec_ready) begin
                    void'(exp_q.pop_front());
                    handshakes++;
                end
            end
            if (!prev_valid) check("valid_latency", 64'(cyc - launch_cyc), 64'd4);
        end
        if (avm_read && !prev_read) begin
            check("launch_reads_addr", avm_address, AW'(MON_ADR_OFFSET));
            check("launch_fifo_nonempty", fifo_q.size() != 0, 1'b1);
            check("launch_gap", (cyc - last_launch) >= int'(5 + S), 1'b1);
            last_launch = cyc;
            launch_cyc  = cyc;
        end
        if (expect_data) begin
            check("data_follows_addr", {avm_read, avm_address}, {1'b1, AW'(MON_DAT_OFFSET)});
            expect_data = 0;
        end

        if (reset) begin
            fifo_q.delete();
            exp_q.delete();
            ref_count       = '0;
            stalled         = 0;
            avm_waitrequest = 1'b1;
            empty_pipe      = '1;
            fifo_empty      = 1'b1;
            last_launch     = -1000;
        end else begin
            fifo_empty = empty_pipe[EMPTY_LAG-1];
            empty_pipe = {empty_pipe[EMPTY_LAG-2:0], fifo_q.size() == 0};
            if (avm_read && !stalled) begin
                avm_waitrequest = 1'b1;
                stalled         = 1;
            end else if (avm_read) begin
                avm_waitrequest = 1'b0;
                stalled         = 0;
                accepts++;
                h.a = '0;
                h.d = '0;
                if (fifo_q.size() != 0) h = fifo_q[0];
                if (avm_address == AW'(MON_ADR_OFFSET)) begin
                    w           = $urandom;
                    w[AW-1:0]   = h.a;
                    avm_readdata = w;
                    expect_data = 1;
                end else begin
                    avm_readdata = h.d;
                    if (fifo_q.size() != 0) void'(fifo_q.pop_front());
                    ref_count = ref_count + 16'd1;
                    if (!flush) exp_q.push_back(h);
                end
            end else begin
                avm_waitrequest = 1'b1;
                stalled         = 0;
            end
        end
        prev_read  = avm_read;
        prev_valid = rec_valid;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r.a = AW'($urandom);
            r.d = $urandom;
            fifo_q.push_back(r);
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && !(fifo_q.size() == 0 && exp_q.size() == 0 && !busy); i++) step();
    endtask

    initial begin
        rec_t r;
        int   hs0;
        int   acc0;

        step(3);
        reset = 1'b0;
        step();
        check("rst_avm_read", avm_read, 1'b0);
        check("rst_avm_address", avm_address, '0);
        check("rst_rec_valid", rec_valid, 1'b0);
        check("rst_rec_addr", rec_addr, '0);
        check("rst_rec_data", rec_data, '0);
        check("rst_rec_count", rec_count, '0);
        check("rst_busy", busy, 1'b0);

        // Single record; with one entry this also covers the stale-empty window.
        accepts   = 0;
        rec_ready = 1'b1;
        enable    = 1'b1;
        r.a = 10'h3A5;
        r.d = 32'hDEADBEEF;
        fifo_q.push_back(r);
        for (int i = 0; i < 40 && !rec_valid; i++) step();
        check("single_valid_seen", rec_valid, 1'b1);
        check("single_addr", rec_addr, 10'h3A5);
        check("single_data", rec_data, 32'hDEADBEEF);
        check("single_count", rec_count, 16'd1);
        step(20);
        check("stale_two_accepts", 64'(accepts), 64'd2);
        check("stale_count", rec_count, 16'd1);
        check("single_idle_busy", busy, 1'b0);

        // Backpressure.
        accepts   = 0;
        rec_ready = 1'b0;
        hs0       = handshakes;
        load(3);
        step(20);
        check("bp_valid_held", rec_valid, 1'b1);
        check("bp_two_accepts", 64'(accepts), 64'd2);
        rec_ready = 1'b1;
        wait_idle(100);
        check("bp_drained", fifo_q.size() == 0 && exp_q.size() == 0 && !busy, 1'b1);
        check("bp_three_out", 64'(handshakes - hs0), 64'd3);
        check("bp_count", rec_count, 16'd4);

        // Flush.
        flush = 1'b1;
        hs0   = handshakes;
        load(4);
        for (int i = 0; i < 20 && !avm_read; i++) step();
        for (int i = 0; i < int'(4 * (4 + S + 1)) && fifo_q.size() != 0; i++) step();
        check("flush_fifo_empty", fifo_q.size(), 0);
        step(10);
        check("flush_no_output", 64'(handshakes - hs0), 64'd0);
        check("flush_count", rec_count, 16'd8);
        flush = 1'b0;

        // Enable drop during RD_ADDR.
        hs0 = handshakes;
        load(1);
        for (int i = 0; i < 20 && !avm_read; i++) step();
        enable = 1'b0;
        wait_idle(40);
        check("endrop_completed", 64'(handshakes - hs0), 64'd1);
        acc0 = accepts;
        load(1);
        step(20);
        check("endrop_no_launch", 64'(accepts - acc0), 64'd0);
        check("endrop_fifo_kept", fifo_q.size(), 1);

        // Reset during RD_DATA.
        enable = 1'b1;
        for (int i = 0; i < 20 && !(avm_read && avm_address == AW'(MON_DAT_OFFSET)); i++) step();
        check("rd_data_reached", {avm_read, avm_address}, {1'b1, AW'(MON_DAT_OFFSET)});
        reset = 1'b1;
        step();
        check("midrst_avm_read", avm_read, 1'b0);
        check("midrst_count", rec_count, '0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", rec_valid, 1'b0);
        reset = 1'b0;
        step(2);

        // Counter wrap.
        force dut.rec_count_q = 16'hFFFF;
        ref_count = 16'hFFFF;
        step();
        release dut.rec_count_q;
        step();
        hs0 = handshakes;
        load(1);
        wait_idle(40);
        check("wrap_out", 64'(handshakes - hs0), 64'd1);
        check("wrap_count", rec_count, 16'd0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            rec_ready = 1'($urandom_range(0, 1));
            enable    = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) load(int'($urandom_range(1, 3)));
            step();
        end
        enable    = 1'b1;
        rec_ready = 1'b1;
        flush     = 1'b0;
        wait_idle(3000);
        check("random_drained", fifo_q.size() == 0 && exp_q.size() == 0 && !busy, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
